// File: rtl/hsv_core_commit_arb_if.sv
// hsv_core_commit_arb_if: bundles the flush handshake, issue-side scoreboard
// update, execution-unit result channels and register-file write port that
// connect the hsv_core commit arbiter to the rest of the pipeline.
// The arbiter connects through the slave modport. The pipeline connects
// through the master modport.
interface hsv_core_commit_arb_if #(
    parameter int NUM_UNITS = 5,
    parameter int DATA_W    = 32,
    parameter int TOKEN_W   = 2,
    parameter int REG_N     = 32
);
    localparam int RA_W = $clog2(REG_N);

    logic                          flush_req;
    logic                          flush_ack;

    logic                          issue_fire_i;
    logic                          issue_rd_we_i;
    logic [RA_W-1:0]               issue_rd_i;

    logic [NUM_UNITS-1:0]          unit_valid_i;
    logic [NUM_UNITS-1:0]          unit_ready_o;
    logic [NUM_UNITS*TOKEN_W-1:0]  unit_token_i;
    logic [NUM_UNITS-1:0]          unit_rd_we_i;
    logic [NUM_UNITS*RA_W-1:0]     unit_rd_i;
    logic [NUM_UNITS*DATA_W-1:0]   unit_rd_data_i;

    logic                          wr_en;
    logic [RA_W-1:0]               wr_addr;
    logic [DATA_W-1:0]             wr_data;

    logic                          commit_o;
    logic [TOKEN_W-1:0]            commit_token;
    logic [REG_N-1:0]              commit_mask;
    logic [63:0]                   instret_o;

    modport master (
        output flush_req, issue_fire_i, issue_rd_we_i, issue_rd_i,
               unit_valid_i, unit_token_i, unit_rd_we_i, unit_rd_i, unit_rd_data_i,
        input  flush_ack, unit_ready_o, wr_en, wr_addr, wr_data,
               commit_o, commit_token, commit_mask, instret_o
    );

    modport slave (
        input  flush_req, issue_fire_i, issue_rd_we_i, issue_rd_i,
               unit_valid_i, unit_token_i, unit_rd_we_i, unit_rd_i, unit_rd_data_i,
        output flush_ack, unit_ready_o, wr_en, wr_addr, wr_data,
               commit_o, commit_token, commit_mask, instret_o
    );
endinterface

// File: rtl/hsv_core_commit_arb.sv
// hsv_core_commit_arb: in-order commit arbiter for the hsv_core pipeline.
// The arbiter accepts execution-unit results strictly in token order. It
// drives a registered register-file write port and keeps the pending-write
// scoreboard (commit_mask) that issue uses for hazard stalls. It also
// acknowledges pipeline flushes.
// Optional feature macro: HSV_COMMIT_INSTRET_EN. When defined, the arbiter
// adds a 64-bit retired-instruction counter on instret_o. When undefined,
// instret_o is tied to zero.
module hsv_core_commit_arb #(
    parameter int NUM_UNITS = 5,
    parameter int DATA_W    = 32,
    parameter int TOKEN_W   = 2,
    parameter int REG_N     = 32
) (
    input  logic                 clk_core,
    input  logic                 rst_core,
    hsv_core_commit_arb_if.slave bus
);
    localparam int RA_W = $clog2(REG_N);

    logic [TOKEN_W-1:0]   exp_tok;
    logic [NUM_UNITS-1:0] match;
    logic [NUM_UNITS-1:0] ready;
    logic                 accept;
    logic                 sel_we;
    logic [RA_W-1:0]      sel_rd;
    logic [DATA_W-1:0]    sel_data;
    logic                 issue_set;

    logic                 wr_en_q;
    logic [RA_W-1:0]      wr_addr_q;
    logic [DATA_W-1:0]    wr_data_q;
    logic                 commit_q;
    logic                 flush_ack_q;
    logic [REG_N-1:0]     mask_q;
    logic [REG_N-1:0]     mask_next;

    // A unit is a candidate when its result carries the token we expect next.
    always_comb begin
        match = '0;
        for (int k = 0; k < NUM_UNITS; k++) begin
            match[k] = bus.unit_valid_i[k] &&
                       (bus.unit_token_i[k*TOKEN_W +: TOKEN_W] == exp_tok);
        end
    end

    // Grant the lowest matching unit. The scan runs downwards so the lowest
    // index overwrites any higher match. A flush suppresses every grant.
    always_comb begin
        ready    = '0;
        sel_we   = 1'b0;
        sel_rd   = '0;
        sel_data = '0;
        for (int k = NUM_UNITS - 1; k >= 0; k--) begin
            if (match[k]) begin
                ready    = '0;
                ready[k] = 1'b1;
                sel_we   = bus.unit_rd_we_i[k];
                sel_rd   = bus.unit_rd_i[k*RA_W +: RA_W];
                sel_data = bus.unit_rd_data_i[k*DATA_W +: DATA_W];
            end
        end
        if (bus.flush_req) begin
            ready = '0;
        end
    end

    assign accept    = |ready;
    assign issue_set = bus.issue_fire_i && bus.issue_rd_we_i && (bus.issue_rd_i != '0);

    // Scoreboard update: a landed write clears its bit and a new issue sets
    // one. The set is applied last so that it wins on a same-bit collision.
    // x0 is never tracked.
    always_comb begin
        mask_next = mask_q;
        if (wr_en_q) begin
            mask_next[wr_addr_q] = 1'b0;
        end
        if (issue_set) begin
            mask_next[bus.issue_rd_i] = 1'b1;
        end
        mask_next[0] = 1'b0;
    end

    // Token counter, registered write port and scoreboard. A flush discards
    // the in-flight state but leaves the last addr/data values in place.
    always_ff @(posedge clk_core) begin
        if (rst_core) begin
            exp_tok   <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            commit_q  <= 1'b0;
            mask_q    <= '0;
        end else if (bus.flush_req) begin
            exp_tok  <= '0;
            wr_en_q  <= 1'b0;
            commit_q <= 1'b0;
            mask_q   <= '0;
        end else begin
            mask_q   <= mask_next;
            commit_q <= accept;
            if (accept) begin
                exp_tok   <= exp_tok + TOKEN_W'(1);
                wr_en_q   <= sel_we && (sel_rd != '0);
                wr_addr_q <= sel_rd;
                wr_data_q <= sel_data;
            end else begin
                wr_en_q <= 1'b0;
            end
        end
    end

    // The flush acknowledge tracks the request with one cycle of delay.
    always_ff @(posedge clk_core) begin
        if (rst_core) begin
            flush_ack_q <= 1'b0;
        end else begin
            flush_ack_q <= bus.flush_req;
        end
    end

`ifdef HSV_COMMIT_INSTRET_EN
    logic [63:0] instret_q;

    // Count retirements. The count survives flushes and wraps naturally.
    always_ff @(posedge clk_core) begin
        if (rst_core) begin
            instret_q <= '0;
        end else if (commit_q) begin
            instret_q <= instret_q + 64'd1;
        end
    end

    assign bus.instret_o = instret_q;
`else
    assign bus.instret_o = '0;
`endif

    assign bus.unit_ready_o = ready;
    assign bus.wr_en        = wr_en_q;
    assign bus.wr_addr      = wr_addr_q;
    assign bus.wr_data      = wr_data_q;
    assign bus.commit_o     = commit_q;
    assign bus.commit_token = exp_tok;
    assign bus.commit_mask  = mask_q;
    assign bus.flush_ack    = flush_ack_q;

    // Two units presenting the expected token at once is a protocol error.
    a_unique_token: assert property (@(posedge clk_core) disable iff (rst_core)
        $onehot0(match));

    // Issue must not dispatch a writer to a register that is still pending.
    a_no_pending_writer: assert property (@(posedge clk_core) disable iff (rst_core)
        !(issue_set && mask_q[bus.issue_rd_i]));
endmodule

// File: doc/hsv_core_commit_arb.md
# hsv_core_commit_arb

Parametrised in-order commit arbiter for the hsv_core pipeline, generalising the fixed five-unit commit stage to NUM_UNITS execution-unit channels. It sits between the execution units and the register file. It accepts completed results strictly in issue order by instruction token and drives a registered register-file write port. It also maintains the pending-write scoreboard (commit_mask) that issue uses for hazard stalls, and acknowledges pipeline flushes.

## Interface
- NUM_UNITS, 5: number of execution-unit result channels (1..8).
- DATA_W, 32: register data width.
- TOKEN_W, 2: instruction token width; tokens wrap modulo 2^TOKEN_W.
- REG_N, 32: number of architectural registers; address width RA_W = $clog2(REG_N).
- clk_core  in  1  core clock, all logic on rising edge.
- rst_core  in  1  synchronous, active-high reset.
- flush_req  in  1  flush request from control/status.
- flush_ack  out  1  flush acknowledge.
- issue_fire_i  in  1  issue dispatched one instruction this cycle.
- issue_rd_we_i  in  1  dispatched instruction writes rd.
- issue_rd_i  in  RA_W  rd of dispatched instruction.
- unit_valid_i  in  NUM_UNITS  per-unit result valid.
- unit_ready_o  out  NUM_UNITS  per-unit result accepted.
- unit_token_i  in  NUM_UNITS*TOKEN_W  per-unit result token, unit k at [k*TOKEN_W +: TOKEN_W].
- unit_rd_we_i  in  NUM_UNITS  result writes rd.
- unit_rd_i  in  NUM_UNITS*RA_W  result rd.
- unit_rd_data_i  in  NUM_UNITS*DATA_W  result value.
- wr_en  out  1  register-file write enable.
- wr_addr  out  RA_W  register-file write address.
- wr_data  out  DATA_W  register-file write data.
- commit_o  out  1  one instruction retired this cycle, with or without a write.
- commit_token  out  TOKEN_W  expected next token.
- commit_mask  out  REG_N  pending-write scoreboard; bit 0 is always 0.
- instret_o  out  64  retired-instruction count; see Configuration.

## Operation
- Token counter exp_tok starts at 0. A unit k matches when unit_valid_i[k] is high and unit_token_i[k] equals exp_tok.
- Accept: unit_ready_o is one-hot on the lowest matching k, and all zero when nothing matches or flush_req is high. Ready is combinational from valid, token and flush.
- On accept: exp_tok increments with wrap (3 to 0 for TOKEN_W=2). The write-port registers load we = unit_rd_we_i[k] && rd != 0, plus the addr and data. commit_o is registered with them.
- Non-matching valid units stall; their ready stays 0 until their token becomes exp_tok.
- Duplicate matching tokens are a protocol error, flagged by a simulation assertion. Lowest index wins.
- Scoreboard set: on issue_fire_i && issue_rd_we_i && issue_rd_i != 0, set commit_mask[issue_rd_i].
- Scoreboard clear: the bit for wr_addr clears at the clock edge ending a cycle with wr_en=1.
- Set and clear of the same bit at the same edge: set wins.
- Issue must not dispatch a writer to a pending register; this is asserted.
- Flush: while flush_req is high, nothing is accepted. At the next edge exp_tok <= 0, commit_mask <= 0, wr_en <= 0 and commit_o <= 0. flush_ack is registered: it rises one cycle after flush_req and falls one cycle after flush_req drops.
- Reset: exp_tok=0, commit_mask=0, wr_en=0, wr_addr=0, wr_data=0, commit_o=0, flush_ack=0, instret_o=0.

## Timing
- Latency: accept in cycle A, wr_en/commit_o high in A+1, mask bit clear visible in A+2. Issue therefore reads the regfile only after the write has landed.
- Throughput: one commit per cycle, back-to-back with consecutive tokens.
- unit_ready_o, commit_token and commit_mask have no combinational path from the wr_* outputs.
- Reset or flush mid-stream discards the pending write-port contents. A write accepted in cycle F-1, where flush_req rises in cycle F, still performs its wr_en in cycle F.

## Configuration
- HSV_COMMIT_INSTRET_EN defined: instret_o is a 64-bit counter. It increments on every commit_o cycle, resets to 0, wraps at 2^64, and is not cleared by flush.
- HSV_COMMIT_INSTRET_EN not defined: instret_o is tied to 0 and no counter is synthesised.

## Test plan
- In-order commit: units 0,1,2 present tokens 0,1,2 simultaneously -> accepted over 3 consecutive cycles. wr_en follows at cycles 1..3 with matching addr/data, and commit_token ends at 3.
- Out-of-order arrival: unit 3 presents token 1 in cycle 0 and unit 1 presents token 0 in cycle 2 -> unit 3 ready stays 0 until cycle 3. Writes occur in token order 0 then 1.
- Wrap and x0: 6 commits with TOKEN_W=2 -> tokens sequence 0,1,2,3,0,1. A result with rd=0, we=1 -> commit_o=1, wr_en=0, and mask bit 0 stays 0.
- Scoreboard: issue x5 writer in cycle 0 -> commit_mask[5]=1 from cycle 1. Its result accepted in cycle 4 -> wr_en in cycle 5, mask[5]=0 from cycle 6.
- Flush: mask=0x0000_0120 with two units valid, flush_req raised for 3 cycles -> no readies. Mask=0 and commit_token=0 next cycle; flush_ack high for cycles 1..3 after the rise.
- Instret (macro defined): 10 commits plus one flush -> instret_o=10. With the macro undefined, instret_o=0 throughout.
